// File: rtl/tx_serial_pkg.sv
// Shared definitions for the 8N1 serial transmitter: FSM encodings,
// frame geometry and the frame builder used on acceptance.
package tx_serial_pkg;

  typedef enum logic [1:0] {
    inicial     = 2'b00,
    transmissao = 2'b01,
    final_tx    = 2'b10
  } estado_t;

  // start + 8 data + stop
  localparam int BITS_FRAME            = 10;
  // 50 MHz / 115200 baud
  localparam int CICLOS_POR_BIT_PADRAO = 434;

  // Frame as it leaves the shift register, LSB first: start(0), data, stop(1)
  function automatic logic [BITS_FRAME-1:0] monta_quadro(input logic [7:0] dados);
    return {1'b1, dados, 1'b0};
  endfunction

endpackage

// File: rtl/tx_serial_8n1_contador_m.sv
// Modulo-M counter used as the baud divider. fim flags the last count so
// the caller can act on the same edge the counter wraps.
module contador_m #(
  parameter int M = 434
) (
  input  logic                 clock,
  input  logic                 zera,
  input  logic                 conta,
  output logic [$clog2(M)-1:0] Q,
  output logic                 fim
);

  localparam logic [$clog2(M)-1:0] ULTIMO = ($clog2(M))'(M - 1);

  assign fim = (Q == ULTIMO);

  // Synchronous clear has priority over counting; wrap to 0 after M-1
  always_ff @(posedge clock) begin
    if (zera)
      Q <= '0;
    else if (conta)
      Q <= fim ? '0 : Q + 1'b1;
  end

endmodule

// File: rtl/tx_serial_8n1.sv
// 8N1 asynchronous serial transmitter. One partida pulse in inicial sends
// one character; pronto pulses for one cycle once the stop bit has ended.
module tx_serial_8n1
  import tx_serial_pkg::*;
#(
  parameter int CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados_ascii,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [1:0] db_estado
);

  estado_t                          estado;
  logic [BITS_FRAME-1:0]            quadro;
  logic [3:0]                       conta_bit;
  logic                             aceita;
  logic                             fim_bit;
  logic                             fim_quadro;
  logic [$clog2(CICLOS_POR_BIT)-1:0] baud_q_unused;

  assign aceita     = (estado == inicial) && partida;
  assign fim_quadro = fim_bit && (conta_bit == 4'(BITS_FRAME - 1));

  // Baud divider: restarts on acceptance so the start bit is a full period
  contador_m #(.M(CICLOS_POR_BIT)) u_baud (
    .clock (clock),
    .zera  (reset || aceita),
    .conta (estado == transmissao),
    .Q     (baud_q_unused),
    .fim   (fim_bit)
  );

  // FSM, shift register and bit counter; data is latched only on acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= inicial;
      quadro    <= '1;
      conta_bit <= '0;
    end else begin
      case (estado)
        inicial: begin
          if (partida) begin
            estado    <= transmissao;
            quadro    <= monta_quadro(dados_ascii);
            conta_bit <= '0;
          end
        end
        transmissao: begin
          if (fim_bit) begin
            quadro <= {1'b1, quadro[BITS_FRAME-1:1]};
            if (fim_quadro) begin
              estado    <= final_tx;
              conta_bit <= '0;
            end else begin
              conta_bit <= conta_bit + 4'd1;
            end
          end
        end
        final_tx: estado <= inicial;
        default:  estado <= inicial;
      endcase
    end
  end

  // Outputs decode state and the register LSB only; line idles high
  assign saida_serial = (estado == transmissao) ? quadro[0] : 1'b1;
  assign ocupado      = (estado == transmissao);
  assign pronto       = (estado == final_tx);
  assign db_estado    = estado;

endmodule

// File: tb/tb_tx_serial_8n1.sv
// Bench for tx_serial_8n1 with CICLOS_POR_BIT=4. A frame-timeline model
// (cycles since acceptance) predicts every output each cycle; directed
// scenarios add hand-computed line patterns and handshake counts.
module tb_tx_serial_8n1;

  localparam int N = 4;
  localparam int F = 10 * N;

  logic       clock;
  logic       reset;
  logic       partida;
  logic [7:0] dados_ascii;
  logic       saida_serial;
  logic       ocupado;
  logic       pronto;
  logic [1:0] db_estado;

  int total = 0;
  int bad   = 0;

  tx_serial_8n1 #(.CICLOS_POR_BIT(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .dados_ascii  (dados_ascii),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: pos = cycles since the accepting edge (-1 when idle)
  int         pos      = -1;
  logic [9:0] mq       = '1;
  bit         model_on = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      pos      <= -1;
      model_on <= 1'b1;
    end else if (pos < 0) begin
      if (partida) begin
        pos <= 0;
        mq  <= {1'b1, dados_ascii, 1'b0};
      end
    end else begin
      pos <= (pos >= F) ? -1 : pos + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_model();
    logic exp_line, exp_oc, exp_pr;
    logic [1:0] exp_st;
    if (!model_on) return;
    exp_oc   = (pos >= 0) && (pos < F);
    exp_pr   = (pos == F);
    exp_line = exp_oc ? mq[pos / N] : 1'b1;
    exp_st   = exp_oc ? 2'b01 : (exp_pr ? 2'b10 : 2'b00);
    chk("model saida_serial", 64'(saida_serial), 64'(exp_line));
    chk("model ocupado",      64'(ocupado),      64'(exp_oc));
    chk("model pronto",       64'(pronto),       64'(exp_pr));
    chk("model db_estado",    64'(db_estado),    64'(exp_st));
  endtask

  // Every wait goes through here so the model is checked each cycle
  task automatic step();
    @(negedge clock);
    chk_model();
  endtask

  function automatic logic [39:0] expand(input logic [9:0] s);
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = s[i / N];
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input bit hold);
    partida     = 1'b1;
    dados_ascii = d;
    step();
    if (!hold) partida = 1'b0;
  endtask

  // Called at the first cycle after acceptance; samples the 40 frame cycles
  task automatic capture(input int inj, output logic [39:0] lv, output int oc, output int pr);
    oc = 0;
    pr = 0;
    lv = '0;
    for (int i = 0; i < 40; i++) begin
      lv[i] = saida_serial;
      if (ocupado) oc++;
      if (pronto)  pr++;
      if (inj >= 0 && i == inj) begin
        partida     = 1'b1;
        dados_ascii = 8'hFF;
      end else if (inj >= 0 && i == inj + 1) begin
        partida = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    logic [39:0] lv;
    int oc, pr, idle, cnt_oc, cnt_pr;

    // 1: reset (with partida high: reset wins), then idle
    reset       = 1'b1;
    partida     = 1'b1;
    dados_ascii = 8'h00;
    repeat (3) step();
    reset   = 1'b0;
    partida = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0 || i == 19) begin
        chk("idle saida", 64'(saida_serial), 64'd1);
        chk("idle ocupado", 64'(ocupado), 64'd0);
        chk("idle pronto", 64'(pronto), 64'd0);
        chk("idle estado", 64'(db_estado), 64'd0);
      end
    end

    // 2: 'A' -> 0,1,0,0,0,0,0,1,0,1
    send(8'h41, 1'b0);
    capture(-1, lv, oc, pr);
    chk("A line", 64'(lv), 64'(expand(10'b1010000010)));
    chk("A ocupado cycles", 64'(oc), 64'd40);
    chk("A pronto early", 64'(pr), 64'd0);
    chk("A pronto", 64'(pronto), 64'd1);
    step();
    chk("A pronto one cycle", 64'(pronto), 64'd0);
    repeat (3) step();

    // 3: 8'h55 with partida/data disturbance at frame cycle 12
    send(8'h55, 1'b0);
    capture(12, lv, oc, pr);
    chk("55 line", 64'(lv), 64'(expand(10'b1010101010)));
    chk("55 pronto", 64'(pronto), 64'd1);
    cnt_oc = 0;
    cnt_pr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ocupado) cnt_oc++;
      if (pronto)  cnt_pr++;
    end
    chk("55 no second frame", 64'(cnt_oc), 64'd0);
    chk("55 single pronto", 64'(cnt_pr), 64'd0);

    // 4: upstream handshake, 8'h4F then 8'h4B
    send(8'h4F, 1'b0);
    capture(-1, lv, oc, pr);
    chk("4F line", 64'(lv), 64'(expand(10'b1010011110)));
    chk("4F pronto", 64'(pronto), 64'd1);
    idle = 0;
    for (int j = 0; j < 3; j++) begin
      if (saida_serial && !ocupado) idle++;
      if (j < 2) step();
    end
    send(8'h4B, 1'b0);
    chk("4F-4B idle gap", 64'(idle), 64'd3);
    capture(-1, lv, oc, pr);
    chk("4B line", 64'(lv), 64'(expand(10'b1010010110)));
    chk("4B pronto", 64'(pronto), 64'd1);
    repeat (3) step();

    // 5: reset mid-frame at frame cycle 17 of 8'h00
    send(8'h00, 1'b0);
    repeat (16) step();
    chk("00 mid line", 64'(saida_serial), 64'd0);
    chk("00 mid ocupado", 64'(ocupado), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort saida", 64'(saida_serial), 64'd1);
    chk("abort ocupado", 64'(ocupado), 64'd0);
    chk("abort estado", 64'(db_estado), 64'd0);
    cnt_pr = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (pronto) cnt_pr++;
    end
    chk("abort no pronto", 64'(cnt_pr), 64'd0);
    send(8'h31, 1'b0);
    capture(-1, lv, oc, pr);
    chk("31 line", 64'(lv), 64'(expand(10'b1001100010)));
    chk("31 pronto", 64'(pronto), 64'd1);
    repeat (3) step();

    // 6: partida held high with 8'h30 -> back-to-back frames, 2 idle cycles
    send(8'h30, 1'b1);
    for (int f = 0; f < 3; f++) begin
      capture(-1, lv, oc, pr);
      chk("30 line", 64'(lv), 64'(expand(10'b1001100000)));
      chk("30 ocupado cycles", 64'(oc), 64'd40);
      idle = 0;
      for (int j = 0; j < 2; j++) begin
        if (saida_serial && !ocupado) idle++;
        step();
      end
      chk("30 idle gap", 64'(idle), 64'd2);
      chk("30 next start", 64'(saida_serial), 64'd0);
    end
    partida = 1'b0;
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_serial_8n1.md
# tx_serial_8n1

Asynchronous serial transmitter, 8 data bits, no parity, 1 stop bit (8N1). It sits directly downstream of the play-analyser control unit. Each one-cycle `partida` pulse from that unit's `envia_partida` state makes this block serialise one ASCII character onto the TX line. When the frame has finished, it returns a one-cycle `pronto` pulse, which the control unit consumes as `pronto_tx`. Bit timing comes from a parameterised clock-cycle divisor, so the block needs no baud clock.

## Interface
- `CICLOS_POR_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud). Legal range is 2 or more.
- `clock` input 1: system clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `partida` input 1: start request. Sampled only in `inicial`.
- `dados_ascii` input 8: character to send. Sampled on the same edge that accepts `partida`.
- `saida_serial` output 1: TX line. Idles at 1.
- `ocupado` output 1: high from acceptance until the end of the stop bit.
- `pronto` output 1: one-cycle pulse after the stop bit completes.
- `db_estado` output 2: current state, for debug.

## Operation
- States:
  - `inicial` (00)
  - `transmissao` (01)
  - `final_tx` (10)
  - Code 11 is unused and goes to `inicial` on the next edge.
- Shift register, 10 bits: {1 (stop), `dados_ascii`[7:0], 0 (start)}.
  - Loaded on acceptance.
  - Shifts right by one at the end of each bit period.
  - `saida_serial` is bit 0 of the register while in `transmissao`, and 1 otherwise.
- Bit-period counter: 0 to `CICLOS_POR_BIT`−1.
  - Cleared on acceptance.
  - `fim_bit` is asserted at count `CICLOS_POR_BIT`−1, and the counter wraps to 0.
- Bit counter: 0 to 9.
  - Incremented on `fim_bit`.
  - The frame ends on `fim_bit` while the bit counter equals 9.
- Transitions:
  - `inicial` goes to `transmissao` on `partida`=1; the shift register and both counters are loaded.
  - `transmissao` goes to `final_tx` at the end of the frame and otherwise stays.
  - `final_tx` goes to `inicial` unconditionally.
- Output decode:
  - `ocupado` = (state == `transmissao`).
  - `pronto` = (state == `final_tx`).
- `partida` is ignored in `transmissao` and `final_tx`. There is no queuing, and `dados_ascii` changes during a frame have no effect.
- Bits go out LSB first.

## Timing
- Reset values: state `inicial`, `saida_serial`=1, `ocupado`=0, `pronto`=0, counters 0, shift register all ones.
- Let edge k be the one where `partida`=1 is accepted in `inicial`. With N = `CICLOS_POR_BIT`:
  - Start bit (0) drives `saida_serial` from cycle k+1 through k+N.
  - Data bit i occupies cycles k+1+(i+1)N through k+(i+2)N.
  - Stop bit occupies k+1+9N through k+10N.
  - `pronto`=1 during cycle k+10N+1 only. The state is `inicial` again at k+10N+2.
- The earliest next acceptance is at edge k+10N+2. The upstream FSM (pronto, then next char, then partida) re-triggers at k+10N+3, which introduces no gap violations.
- `partida` held high continuously produces back-to-back frames with 2 idle-high cycles between them.
- Reset asserted mid-frame:
  - On the next edge, `saida_serial`=1 and `ocupado`=0.
  - No `pronto` pulse is generated.
  - A truncated frame on the line is acceptable.
- Reset and `partida` in the same cycle: reset wins and no frame starts.
- There is no combinational path from inputs to outputs. All outputs are registered or decoded from state and register bits.

## Structure
- Shared package/include `tx_serial_pkg`:
  - State encodings `inicial`, `transmissao`, `final_tx`.
  - Frame length constant `BITS_FRAME`=10.
  - Default `CICLOS_POR_BIT`=434.
- One sub-module, `contador_m`:
  - Parameter `M`, ports `clock`, `zera`, `conta`, `Q`, `fim`.
  - Instantiated once with M=`CICLOS_POR_BIT` as the baud divider.
  - The 4-bit bit counter stays inline.
- The top level holds the FSM, the shift register and the bit counter. Expected size is about 150 to 200 lines including the sub-module.

## Test plan
All scenarios use `CICLOS_POR_BIT`=4.
1. Reset, then idle for 20 cycles → `saida_serial`=1, `ocupado`=0 and `pronto`=0 throughout; `db_estado`=00.
2. `partida` pulse with `dados_ascii`=8'h41 ('A') → the line reads 0,1,0,0,0,0,0,1,0,1, each bit held exactly 4 cycles, starting the cycle after acceptance; `ocupado` high for 40 cycles; `pronto` high for exactly 1 cycle at acceptance+41.
3. Send 8'h55, then toggle `partida` and change `dados_ascii` to 8'hFF at cycle 12 of the frame → the frame still sends 0,1,0,1,0,1,0,1,0,1; no second frame; a single `pronto`.
4. Emulate the upstream handshake: send 8'h4F then 8'h4B, re-pulsing `partida` 2 cycles after each `pronto` → two complete frames; 3 idle-high cycles between the end of the first stop bit and the second start bit.
5. Assert `reset` for 1 cycle at cycle 17 of a frame sending 8'h00 → `saida_serial`=1 and `ocupado`=0 from the next edge; no `pronto`; a subsequent `partida` with 8'h31 transmits correctly.
6. Hold `partida`=1 constantly with `dados_ascii`=8'h30 → back-to-back frames, each 40 cycles plus 2 idle-high cycles; every frame is 0,0,0,0,0,1,1,0,0,1.
